// File: rtl/mux_key_table.sv
`default_nettype none
// ============================================================================
// mux_key_table : writable {key, data, valid} table, one registered lookup per
//                 cycle via valid/ready, with saturating hit/miss counters.
// Revision      : 1.0
// ============================================================================
module mux_key_table #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  parameter int CNT_LEN  = 16,
  localparam int IDX_LEN = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_vld,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_sel,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_LEN-1:0]  rsp_idx,
  output logic [CNT_LEN-1:0]  hit_cnt,
  output logic [CNT_LEN-1:0]  miss_cnt
);

  localparam logic [CNT_LEN-1:0] c_CNT_MAX = {CNT_LEN{1'b1}};

  logic [KEY_LEN-1:0]  r_key  [NR_KEY];
  logic [DATA_LEN-1:0] r_data [NR_KEY];
  logic [NR_KEY-1:0]   r_vld;

  logic                r_rsp_valid;
  logic [DATA_LEN-1:0] r_rsp_data;
  logic                r_rsp_hit;
  logic [IDX_LEN-1:0]  r_rsp_idx;
  logic [CNT_LEN-1:0]  r_hit_cnt;
  logic [CNT_LEN-1:0]  r_miss_cnt;

  logic                w_accept;
  logic                w_hit;
  logic [IDX_LEN-1:0]  w_idx;
  logic [DATA_LEN-1:0] w_data;
  logic                w_wr_ok;
  logic [NR_KEY-1:0]   w_wr_sel;

  // clr drops a same-edge write; out-of-range indices simply match no entry
  assign w_wr_ok = wr_en && !clr;

  for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_wsel
    assign w_wr_sel[gi] = w_wr_ok && (wr_idx == IDX_LEN'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_wr_sel[i]) begin
        r_key[i]  <= wr_key;
        r_data[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (clr) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (w_wr_sel[i]) r_vld[i] <= wr_vld;
      end
    end
  end

  // Descending scan so the lowest matching index is the last to assign
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_data = default_out;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (r_vld[i] && (r_key[i] == req_sel)) begin
        w_hit  = 1'b1;
        w_idx  = IDX_LEN'(i);
        w_data = r_data[i];
      end
    end
  end

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_data;
        r_rsp_hit   <= w_hit;
        r_rsp_idx   <= w_idx;
        if (w_hit && (r_hit_cnt != c_CNT_MAX)) r_hit_cnt <= r_hit_cnt + CNT_LEN'(1);
        if (!w_hit && (r_miss_cnt != c_CNT_MAX)) r_miss_cnt <= r_miss_cnt + CNT_LEN'(1);
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_idx   = r_rsp_idx;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule
`default_nettype wire

// File: doc/mux_key_table.md
Name: mux_key_table

Overview:
- Programmable, registered successor to the combinational key-lookup mux.
- Holds NR_KEY writable {key, data} entries, each with its own valid bit.
- Answers one lookup per cycle through a valid/ready request/response pair, returning data, hit flag and matching index.
- Used wherever the datapath needs a runtime-reconfigurable decode table, for example opcode-to-control maps or address-to-device selection.

Parameters:
- NR_KEY, 4, number of table entries (≥1).
- KEY_LEN, 4, key width in bits.
- DATA_LEN, 8, data width in bits.
- IDX_LEN, (NR_KEY>1 ? $clog2(NR_KEY) : 1), entry-index width (derived localparam; do not override).
- CNT_LEN, 16, width of the hit and miss statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  invalidate all entries.
- wr_en  in  1  write one entry.
- wr_idx  in  IDX_LEN  entry to write.
- wr_key  in  KEY_LEN  key to store.
- wr_data  in  DATA_LEN  data to store.
- wr_vld  in  1  valid bit to store; 0 deletes the entry.
- req_valid  in  1  lookup request present.
- req_ready  out  1  block can accept a request.
- req_sel  in  KEY_LEN  key to look up.
- default_out  in  DATA_LEN  data returned on a miss.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_LEN  looked-up data, or default_out on a miss.
- rsp_hit  out  1  1 = some valid entry matched.
- rsp_idx  out  IDX_LEN  lowest matching index; 0 on a miss.
- hit_cnt  out  CNT_LEN  number of accepted lookups that hit.
- miss_cnt  out  CNT_LEN  number of accepted lookups that missed.

Behaviour:
- Reset (rst_n=0, asynchronous): all entry valid bits=0, rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_idx=0, hit_cnt=0, miss_cnt=0. Key/data storage is not reset.
- Reset released mid-transaction: any in-flight response is lost; req_ready=1 in the first cycle after release.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (single output register, no extra bubble).
  - A request is accepted on an edge where req_valid && req_ready.
  - A response is consumed on an edge where rsp_valid && rsp_ready.
  - Accept and consume in the same edge: the new result replaces the old one and rsp_valid stays 1.
  - Consume without accept: rsp_valid goes to 0.
  - While rsp_valid && !rsp_ready: all rsp_* outputs hold stable.
- Latency: exactly 1 cycle from acceptance to rsp_valid=1. Full throughput of 1 lookup per cycle while rsp_ready=1.
- Match rule:
  - Entry i matches when valid[i] && key[i]==req_sel.
  - Multiple matches resolve by priority, not OR-merge: the lowest i wins, giving rsp_idx=i and rsp_data=data[i].
  - No match: rsp_hit=0, rsp_idx=0, rsp_data=default_out, sampled at the accept edge.
- Table writes:
  - On wr_en=1, entry wr_idx takes {wr_key, wr_data, wr_vld} at the edge.
  - wr_idx ≥ NR_KEY: the write is ignored.
  - Write and lookup on the same edge: the lookup sees the table as it was before the edge (read-before-write).
- Clear:
  - clr=1 zeroes every valid bit at the edge.
  - clr and wr_en on the same edge: clr wins and the write is dropped.
  - A lookup accepted on the same edge as clr still uses the pre-clear table.
- Counters:
  - On each accepted request, hit_cnt or miss_cnt increments by 1 according to the match result.
  - Both counters saturate at 2^CNT_LEN−1 with no wrap.
  - Only reset zeroes them; clr does not.
- NR_KEY=1: rsp_idx is always 0; wr_idx bit 0 must be 0 for the write to take effect.

Test Plan:
- Reset, write entry 2 = {key 0x5, data 0xA7, vld 1}, request sel=0x5 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_hit=1, rsp_idx=2, rsp_data=0xA7, hit_cnt=1.
- Entries 1 and 3 both hold key 0x9 (data 0x11 and 0x33), lookup 0x9 -> rsp_idx=1, rsp_data=0x11. Delete entry 1 (wr_vld=0), repeat the lookup -> rsp_idx=3, rsp_data=0x33.
- Lookup 0xF with default_out=0xEE, no matching entry -> rsp_hit=0, rsp_idx=0, rsp_data=0xEE, miss_cnt=1.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 and changing req_sel -> req_ready=0 from the cycle after the first accept, rsp_* stable. Raise rsp_ready -> back-to-back responses with no bubble; counters count only accepted requests.
- Same edge: wr_en rewrites entry 0 from key 0x3 to 0x4 while a lookup of 0x3 is accepted -> that response hits idx 0 with the old data; a following lookup of 0x3 misses. Same edge clr+wr_en -> all entries invalid afterwards.
- CNT_LEN=2, 5 hits -> hit_cnt sticks at 3. Assert rst_n low while rsp_valid=1 -> outputs zero immediately, without waiting for a clock edge.
